imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream of the CPU core: receives a program as a byte stream (UART receiver or debug bridge) over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them into instruction memory through a dedicated write port.
- Holds the core in reset until a checksum-verified load completes.
- Frame format: length (2 bytes, LE, word count N) | N×4 payload bytes | 1 checksum byte.

Parameters:
- ADDR_W, 16, width of instruction-memory byte address (matches pc width)
- DEPTH_WORDS, 256, maximum loadable words; N above this is rejected
- BASE_ADDR, 16'h0000, byte address of first word written

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a new load
- rx_valid  input  1  byte available on rx_data
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader accepts byte this cycle
- imem_wr_en  output  1  one-cycle instruction-memory write strobe
- imem_wr_addr  output  ADDR_W  byte address of write, word-aligned
- imem_wr_data  output  32  word to write
- cpu_reset  output  1  held high to keep the core in reset
- busy  output  1  load in progress
- done  output  1  last load succeeded
- error  output  1  last load failed
- words_loaded  output  16  count of words written in current/last load

Behaviour:
- Clocking: one clock (clk). reset is synchronous, active-high.
- Reset values: state IDLE, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0. Checksum accumulator and byte counter are cleared.
- Byte acceptance: a byte transfers on rx_valid && rx_ready. rx_ready is high only in LEN_LO, LEN_HI, DATA and CSUM. rx_ready is combinational from state only, never from rx_valid.
- IDLE: cpu_reset=1. On start, go to LEN_LO; clear words_loaded, checksum, done and error; set busy=1.
- LEN_LO / LEN_HI: capture N[7:0], then N[15:8].
  - After LEN_HI, if N > DEPTH_WORDS, go to ERROR.
  - Else if N == 0, go to CSUM.
  - Else go to DATA.
- DATA: byte k of a word (k=0..3) fills bits [8k+7:8k].
  - When byte 3 is accepted in cycle t, at t+1: imem_wr_en=1 for exactly one cycle, imem_wr_addr=BASE_ADDR+4×words_loaded (pre-increment value), imem_wr_data=assembled word. words_loaded increments at the same edge.
  - After the Nth word's byte 3, go to CSUM. Address wraps modulo 2^ADDR_W.
- Checksum: running XOR of both length bytes and all payload bytes.
  - CSUM accepts one byte. If it equals the accumulator, go to DONE; otherwise go to ERROR.
- DONE: entered at t+1 after the checksum byte. done=1, busy=0, cpu_reset=0. Holds until start or reset.
- ERROR: error=1, busy=0, cpu_reset=1. Holds until start or reset.
- start while busy: ignored. start in IDLE, DONE or ERROR: restarts, and cpu_reset returns to 1 at the next edge.
- Stalls: rx_valid low for any number of cycles simply pauses; no timeout.
- Reset mid-load: returns to IDLE immediately. No further writes are issued. Words already written stay in memory.
- Outputs: all registered except rx_ready. Write address and data are stable only while imem_wr_en=1.

Test Plan:
- Good 2-word load: start, then bytes 02 00 78 56 34 12 EF BE AD DE 28, one per cycle.
  - Writes (0x0000, 0x12345678) and (0x0004, 0xDEADBEEF).
  - words_loaded=2. done=1 and cpu_reset=0 one cycle after byte 28 is accepted.
- Same frame with checksum 29 → no change to the two writes; error=1, done=0, cpu_reset stays 1.
- Length 01 01 (257) with DEPTH_WORDS=256 → error=1 the cycle after the second length byte; rx_ready=0; no writes.
- Length 00 00, checksum 00 → done=1, zero write strobes, words_loaded=0.
- Good 2-word frame with random rx_valid gaps, including a 10-cycle gap mid-word:
  - Identical writes and final state to the back-to-back case.
  - A start pulse injected during DATA is ignored.
- reset asserted after 6 payload bytes → the first word is written, the second never is.
  - Next cycle: state IDLE, cpu_reset=1, busy=0, rx_ready=0.
  - A subsequent good frame loads normally.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// little-endian 32-bit words into instruction memory, holding the core in reset until done.
module imem_boot_loader #(
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        accept;
  logic        start_ok;
  logic        last_word;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len_lo};
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign last_word = (words_loaded + 16'd1) == len;

  // NOTE: every signal driven from always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    rx_ready   = 1'b0;
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          if (len_full > 16'(DEPTH_WORDS)) state_next = S_ERROR;
          else if (len_full == 16'd0)      state_next = S_CSUM;
          else                             state_next = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (accept && byte_idx == 2'd3 && last_word) state_next = S_CSUM;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      busy      <= (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                   (state_next == S_DATA)   || (state_next == S_CSUM);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERROR);
      cpu_reset <= (state_next != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      words_loaded <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      if (start_ok) begin
        words_loaded <= '0;
        csum         <= '0;
        byte_idx     <= '0;
      end
      if (accept) begin
        unique case (state)
          S_LEN_LO: begin
            len_lo <= rx_data;
            csum   <= csum ^ rx_data;
          end
          S_LEN_HI: begin
            len  <= len_full;
            csum <= csum ^ rx_data;
          end
          S_DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Address uses the pre-increment count and wraps at ADDR_W bits.
                imem_wr_en   <= 1'b1;
                imem_wr_addr <= BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
                imem_wr_data <= {rx_data, word_buf};
                words_loaded <= words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
